byte_driver: RTL

BYTE_DRIVER -- requirements
Module: byte_driver

---
 rtl/byte_driver_pkg.sv | 16 +
 rtl/byte_fifo.sv | 68 ++++++
 rtl/byte_driver.sv | 116 +++++++++++
 3 files changed

// File: rtl/byte_driver_pkg.sv
// Shared types and constants for the byte driver.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package byte_driver_pkg;

  // Width of every queued and transmitted byte.
  localparam int BYTE_W = 8;

  // Transmit FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/byte_fifo.sv
// Byte queue: DEPTH-entry FIFO with occupancy count, head shown combinationally.
// Latency: a pushed byte is visible at head the cycle after the push if the queue was empty.
// Backpressure: pushes while full are dropped; pops while empty are ignored.
module byte_fifo
  import byte_driver_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [BYTE_W-1:0]      push_data,
  input  logic                   pop,
  output logic [BYTE_W-1:0]      head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              push_ok, pop_ok;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Next-state pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/byte_driver.sv
// Queues bytes and, on start, streams them to a valid/ready sink with GAP idle cycles between bytes.
// Latency: first valid one cycle after start; GAP=0 with ready high gives one byte per cycle.
// Backpressure: data/valid held until ready; full queue drops writes. Optional parity via BYTE_DRIVER_PARITY_EN.
module byte_driver
  import byte_driver_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int GAP   = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  output logic                   full,
  input  logic                   start,
  output logic [7:0]             data,
  output logic                   valid,
  input  logic                   ready,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] count
`ifdef BYTE_DRIVER_PARITY_EN
  ,
  output logic                   parity
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  // Counter holds GAP-1 at most, so $clog2(GAP) bits suffice.
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

  state_t          state_q, state_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;

  logic [7:0]      fifo_head;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic            accept;
  logic            push_ok;
  logic            last;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (accept),
    .head      (fifo_head),
    .full      (full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign accept  = (state_q == ST_SEND) && ready;
  assign push_ok = wr_en && !full;
  // A byte pushed in the same cycle as the final accept keeps the transmission going.
  assign last    = accept && (fifo_count == CW'(1)) && !push_ok;

  assign valid = valid_q;
  assign data  = valid_q ? fifo_head : 8'h00;
  assign busy  = (state_q != ST_IDLE);
  assign done  = done_q;
  assign count = fifo_count;

`ifdef BYTE_DRIVER_PARITY_EN
  assign parity = valid_q ? ^fifo_head : 1'b0;
`endif

  // Transmit FSM next-state: idle until started, send with hold-until-accepted, then optional gap.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !fifo_empty) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (accept) begin
          if (last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (GAP > 0) begin
            state_d   = ST_GAP;
            gap_cnt_d = GAP_LOAD;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) state_d = ST_SEND;
        else                 gap_cnt_d = gap_cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    valid_d = (state_d == ST_SEND);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

endmodule
